// File: rtl/vc_fifo_bank.sv
// Bank of NUM_VC independent first-word-fall-through FIFOs sharing one push and one pop port.
// Every channel's head flit is presented in parallel for the allocator.
module vc_fifo_bank #(
    parameter int DATA_WIDTH = 32,
    parameter int FIFO_DEPTH = 8,
    parameter int NUM_VC     = 4,
    parameter int AF_LEVEL   = 6,
    localparam int VC_W      = $clog2(NUM_VC),
    localparam int OCC_W     = $clog2(FIFO_DEPTH + 1)
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         wr_en,
    input  logic [VC_W-1:0]              wr_vc,
    input  logic [DATA_WIDTH-1:0]        din,
    input  logic                         rd_en,
    input  logic [VC_W-1:0]              rd_vc,
    input  logic [NUM_VC-1:0]            flush,
    output logic [NUM_VC*DATA_WIDTH-1:0] dout,
    output logic [NUM_VC-1:0]            empty,
    output logic [NUM_VC-1:0]            full,
    output logic [NUM_VC-1:0]            almost_full,
    output logic [NUM_VC*OCC_W-1:0]      occupancy,
    output logic                         overflow,
    output logic                         underflow
);

    localparam int AW    = $clog2(FIFO_DEPTH);
    localparam int PTR_W = AW + 1;

    logic [PTR_W-1:0]      r_head [NUM_VC];
    logic [PTR_W-1:0]      r_tail [NUM_VC];
    logic [DATA_WIDTH-1:0] r_ram  [NUM_VC][FIFO_DEPTH];
    logic                  r_overflow;
    logic                  r_underflow;

    logic [PTR_W-1:0]      w_diff [NUM_VC];
    logic [NUM_VC-1:0]     w_empty;
    logic [NUM_VC-1:0]     w_full;
    logic                  w_same_vc;
    logic                  w_pop_ok;
    logic                  w_push_ok;

    always_comb begin
        dout        = '0;
        occupancy   = '0;
        almost_full = '0;
        w_empty     = '0;
        w_full      = '0;
        for (int v = 0; v < NUM_VC; v++) begin
            w_diff[v]  = r_head[v] - r_tail[v];
            w_empty[v] = (r_head[v] == r_tail[v]);
            w_full[v]  = (r_head[v][AW] != r_tail[v][AW]) &&
                         (r_head[v][AW-1:0] == r_tail[v][AW-1:0]);
            occupancy[v*OCC_W +: OCC_W] = OCC_W'(w_diff[v]);
            almost_full[v] = (OCC_W'(w_diff[v]) >= OCC_W'(AF_LEVEL));
            if (!w_empty[v])
                dout[v*DATA_WIDTH +: DATA_WIDTH] = r_ram[v][r_tail[v][AW-1:0]];
        end
    end

    assign empty     = w_empty;
    assign full      = w_full;
    assign overflow  = r_overflow;
    assign underflow = r_underflow;

    // A pop on the same VC frees the slot this push needs, so a full VC still accepts it.
    assign w_same_vc = (wr_vc == rd_vc);
    assign w_pop_ok  = rd_en & ~w_empty[rd_vc];
    assign w_push_ok = wr_en & (~w_full[wr_vc] | (w_pop_ok & w_same_vc));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int v = 0; v < NUM_VC; v++) begin
                r_head[v] <= '0;
                r_tail[v] <= '0;
            end
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else begin
            for (int v = 0; v < NUM_VC; v++) begin
                if (flush[v]) begin
                    r_head[v] <= '0;
                    r_tail[v] <= '0;
                end else begin
                    if (w_push_ok && (wr_vc == VC_W'(v)))
                        r_head[v] <= r_head[v] + 1'b1;
                    if (w_pop_ok && (rd_vc == VC_W'(v)))
                        r_tail[v] <= r_tail[v] + 1'b1;
                end
            end
            if (wr_en && w_full[wr_vc] && !(w_pop_ok && w_same_vc) && !flush[wr_vc])
                r_overflow <= 1'b1;
            if (rd_en && w_empty[rd_vc] && !flush[rd_vc])
                r_underflow <= 1'b1;
        end
    end

    // Storage carries no reset; stale entries are never visible because dout masks empty VCs.
    always_ff @(posedge clk) begin
        if (w_push_ok && !flush[wr_vc])
            r_ram[wr_vc][r_head[wr_vc][AW-1:0]] <= din;
    end

endmodule

// File: tb/tb_vc_fifo_bank.sv
// Directed bench for vc_fifo_bank: a table of single-cycle vectors with expected
// post-edge state, followed by hand-written reset sequences.
module tb_vc_fifo_bank;

    localparam int DW = 32;
    localparam int NV = 4;
    localparam int OW = 4;

    logic           clk;
    logic           rst;
    logic           wr_en;
    logic [1:0]     wr_vc;
    logic [DW-1:0]  din;
    logic           rd_en;
    logic [1:0]     rd_vc;
    logic [NV-1:0]  flush;
    logic [NV*DW-1:0] dout;
    logic [NV-1:0]  empty;
    logic [NV-1:0]  full;
    logic [NV-1:0]  almost_full;
    logic [NV*OW-1:0] occupancy;
    logic           overflow;
    logic           underflow;

    vc_fifo_bank #(.DATA_WIDTH(DW), .FIFO_DEPTH(8), .NUM_VC(NV), .AF_LEVEL(6)) dut (
        .clk(clk), .rst(rst), .wr_en(wr_en), .wr_vc(wr_vc), .din(din),
        .rd_en(rd_en), .rd_vc(rd_vc), .flush(flush), .dout(dout), .empty(empty),
        .full(full), .almost_full(almost_full), .occupancy(occupancy),
        .overflow(overflow), .underflow(underflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic          we;
        logic [1:0]    wv;
        logic [31:0]   d;
        logic          re;
        logic [1:0]    rv;
        logic [3:0]    fl;
        int            c;
        logic [3:0]    occ;
        logic [31:0]   dt;
        logic [3:0]    e;
        logic [3:0]    f;
        logic [3:0]    af;
        logic          ov;
        logic          ud;
    } vec_t;

    vec_t vq[$];
    int   n_checks = 0;
    int   n_err    = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic add(input int we, input int wv, input int d, input int re, input int rv,
                       input int fl, input int c, input int occ, input int dt, input int e,
                       input int f, input int af, input int ov, input int ud);
        vec_t t;
        t.we = we[0];  t.wv = wv[1:0]; t.d = d;      t.re = re[0];
        t.rv = rv[1:0]; t.fl = fl[3:0]; t.c = c;     t.occ = occ[3:0];
        t.dt = dt;     t.e = e[3:0];   t.f = f[3:0]; t.af = af[3:0];
        t.ov = ov[0];  t.ud = ud[0];
        vq.push_back(t);
    endtask

    task automatic idle_inputs();
        wr_en = 1'b0; wr_vc = 2'd0; din = '0; rd_en = 1'b0; rd_vc = 2'd0; flush = '0;
    endtask

    task automatic chk_reset_state(input string tag);
        chk({tag, " empty"},     64'(empty),       64'hF);
        chk({tag, " full"},      64'(full),        64'h0);
        chk({tag, " afull"},     64'(almost_full), 64'h0);
        chk({tag, " occupancy"}, 64'(occupancy),   64'h0);
        chk({tag, " dout_lo"},   dout[63:0],       64'h0);
        chk({tag, " dout_hi"},   dout[127:64],     64'h0);
        chk({tag, " overflow"},  64'(overflow),    64'h0);
        chk({tag, " underflow"}, 64'(underflow),   64'h0);
    endtask

    initial begin
        idle_inputs();
        rst = 1'b0;
        #1;
        chk_reset_state("init");
        repeat (2) @(negedge clk);
        rst = 1'b1;

        // Fill VC2; almost_full rises with the 6th flit, full with the 8th.
        for (int k = 1; k <= 8; k++)
            add(1, 2, 'hA0 + k - 1, 0, 0, 0, 2, k, 'hA0, 'b1011,
                (k == 8) ? 'b0100 : 0, (k >= 6) ? 'b0100 : 0, 0, 0);
        // Full VC2: simultaneous push+pop accepted, then a lone push overflows.
        add(1, 2, 'hB0, 1, 2, 0, 2, 8, 'hA1, 'b1011, 'b0100, 'b0100, 0, 0);
        add(1, 2, 'hC0, 0, 0, 0, 2, 8, 'hA1, 'b1011, 'b0100, 'b0100, 1, 0);
        // Drain across the wrap: A2..A7 then B0 become head, then empty.
        for (int j = 1; j <= 8; j++)
            add(0, 0, 0, 1, 2, 0, 2, 8 - j,
                (j <= 6) ? ('hA1 + j) : ((j == 7) ? 'hB0 : 0),
                (j < 8) ? 'b1011 : 'b1111, 0, (j <= 2) ? 'b0100 : 0, 1, 0);
        // Interleave VC0 / VC3.
        add(1, 0, 'h11, 0, 0, 0, 0, 1, 'h11, 'b1110, 0, 0, 1, 0);
        add(1, 3, 'h33, 0, 0, 0, 3, 1, 'h33, 'b0110, 0, 0, 1, 0);
        add(1, 0, 'h12, 0, 0, 0, 0, 2, 'h11, 'b0110, 0, 0, 1, 0);
        add(0, 0, 0,    1, 0, 0, 0, 1, 'h12, 'b0110, 0, 0, 1, 0);
        add(0, 0, 0,    1, 3, 0, 3, 0, 0,    'b1110, 0, 0, 1, 0);
        add(0, 0, 0,    1, 0, 0, 0, 0, 0,    'b1111, 0, 0, 1, 0);
        // Push into empty VC1 with same-cycle pop: pop refused, underflow set.
        add(1, 1, 'h55, 1, 1, 0, 1, 1, 'h55, 'b1101, 0, 0, 1, 1);
        for (int k = 2; k <= 5; k++)
            add(1, 1, 'h54 + k, 0, 0, 0, 1, k, 'h55, 'b1101, 0, 0, 1, 1);
        add(1, 0, 'h77, 0, 0, 0, 0, 1, 'h77, 'b1100, 0, 0, 1, 1);
        // Flush VC1 beats the concurrent push; VC0 untouched.
        add(1, 1, 'h5A, 0, 0, 'b0010, 1, 0, 0, 'b1110, 0, 0, 1, 1);
        add(0, 0, 0, 0, 0, 0, 0, 1, 'h77, 'b1110, 0, 0, 1, 1);
        add(0, 0, 0, 1, 0, 0, 0, 0, 0,    'b1111, 0, 0, 1, 1);

        for (int i = 0; i < vq.size(); i++) begin
            @(negedge clk);
            wr_en = vq[i].we; wr_vc = vq[i].wv; din = vq[i].d;
            rd_en = vq[i].re; rd_vc = vq[i].rv; flush = vq[i].fl;
            @(posedge clk);
            #1;
            chk($sformatf("v%0d empty", i), 64'(empty), 64'(vq[i].e));
            chk($sformatf("v%0d full", i),  64'(full),  64'(vq[i].f));
            chk($sformatf("v%0d afull", i), 64'(almost_full), 64'(vq[i].af));
            chk($sformatf("v%0d occ%0d", i, vq[i].c),
                64'(occupancy[vq[i].c*OW +: OW]), 64'(vq[i].occ));
            chk($sformatf("v%0d dout%0d", i, vq[i].c),
                64'(dout[vq[i].c*DW +: DW]), 64'(vq[i].dt));
            chk($sformatf("v%0d overflow", i),  64'(overflow),  64'(vq[i].ov));
            chk($sformatf("v%0d underflow", i), 64'(underflow), 64'(vq[i].ud));
        end

        // Reset asserted mid-cycle during traffic clears everything at once.
        @(negedge clk);
        idle_inputs();
        wr_en = 1'b1; wr_vc = 2'd0; din = 32'hDEAD_0001;
        @(posedge clk);
        #3;
        rst = 1'b0;
        #1;
        chk_reset_state("async_rst");
        @(posedge clk);
        #1;
        chk_reset_state("rst_held");

        // First push after release is accepted on the first edge.
        @(negedge clk);
        rst = 1'b1;
        wr_en = 1'b1; wr_vc = 2'd3; din = 32'h0000_0099;
        @(posedge clk);
        #1;
        chk("post_rst occ3",  64'(occupancy[3*OW +: OW]), 64'd1);
        chk("post_rst dout3", 64'(dout[3*DW +: DW]),      64'h99);
        chk("post_rst empty", 64'(empty),                 64'h7);
        @(negedge clk);
        idle_inputs();

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
